soc_system_pio_controle_start: RTL and testbench

- Avalon-MM slave through which the HPS launches the accelerator and tracks each run.
- Drives the accelerator's start strobe and watches its finish line.
- Reports done, timeout and error status, raises an optional interrupt, and records the run length in cycles.
- Counterpart of the finish-input PIO: the command/launch side of the same control handshake.

---
 rtl/soc_system_pio_controle_start_if.sv | 10 +
 rtl/soc_system_pio_controle_start.sv | 107 ++++++++++
 tb/tb_soc_system_pio_controle_start.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/soc_system_pio_controle_start_if.sv
// soc_system_pio_controle_start_if: Avalon-MM register bus between the HPS and the launch controller.
interface soc_system_pio_controle_start_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport slave (input address, chipselect, write_n, writedata, output readdata);
    modport master (output address, chipselect, write_n, writedata, input readdata);
endinterface

// File: rtl/soc_system_pio_controle_start.sv
// soc_system_pio_controle_start: launches the accelerator with a start pulse, tracks finish/timeout/err and run length.
module soc_system_pio_controle_start #(
    parameter int PULSE_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    soc_system_pio_controle_start_if.slave       bus,
    input  logic                                 in_finish,
    output logic                                 out_port,
    output logic                                 irq
);
    typedef enum logic [1:0] {IDLE, PULSE, RUN} state_t;
    state_t      state, state_n;
    logic [7:0]  pcnt, pcnt_n;
    logic [31:0] rcnt, rcnt_n, cycles, cycles_n, cyc_inc, readdata_n;
    logic        finish_d, fe, wr, start, busy, out_n;
    logic        done, done_n, timeout, timeout_n, err, err_n;
    logic [1:0]  mask;
    logic [2:0]  clr;
    logic        unused_ok;
    assign unused_ok = &{1'b0, bus.writedata[31:3]};
    assign wr      = bus.chipselect & ~bus.write_n;
    assign start   = wr && bus.address == 2'd0 && bus.writedata[0];
    assign clr     = (wr && bus.address == 2'd1) ? bus.writedata[2:0] : 3'b000;
    assign fe      = in_finish & ~finish_d;
    assign busy    = state != IDLE;
    assign cyc_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
    // Hardware sets are assigned after the W1C terms so a set wins over a same-cycle clear.
    always_comb begin
        state_n   = state;
        pcnt_n    = pcnt;
        rcnt_n    = rcnt;
        cycles_n  = cycles;
        out_n     = out_port;
        done_n    = done & ~clr[0];
        timeout_n = timeout & ~clr[1];
        err_n     = (err & ~clr[2]) | (start & busy);
        case (state)
            IDLE: if (start) begin
                state_n   = PULSE;
                done_n    = 1'b0;
                timeout_n = 1'b0;
                cycles_n  = 32'd0;
                pcnt_n    = 8'(PULSE_LEN - 1);
                out_n     = 1'b1;
            end
            PULSE: begin
                cycles_n = cyc_inc;
                pcnt_n   = pcnt - 8'd1;
                if (fe) begin
                    out_n   = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (pcnt == 8'd0) begin
                    out_n   = 1'b0;
                    rcnt_n  = 32'd0;
                    state_n = RUN;
                end
            end
            RUN: begin
                cycles_n = cyc_inc;
                rcnt_n   = rcnt + 32'd1;
                if (fe) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && rcnt + 32'd1 == 32'(TIMEOUT_CYCLES)) begin
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        readdata_n = bus.address == 2'd0 ? {30'b0, out_port, busy} :
                     bus.address == 2'd1 ? {29'b0, err, timeout, done} :
                     bus.address == 2'd2 ? {30'b0, mask} : cycles;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            pcnt         <= 8'd0;
            rcnt         <= 32'd0;
            cycles       <= 32'd0;
            out_port     <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            err          <= 1'b0;
            mask         <= 2'b00;
            finish_d     <= 1'b0;
            irq          <= 1'b0;
            bus.readdata <= 32'd0;
        end else begin
            state        <= state_n;
            pcnt         <= pcnt_n;
            rcnt         <= rcnt_n;
            cycles       <= cycles_n;
            out_port     <= out_n;
            done         <= done_n;
            timeout      <= timeout_n;
            err          <= err_n;
            mask         <= (wr && bus.address == 2'd2) ? bus.writedata[1:0] : mask;
            finish_d     <= in_finish;
            irq          <= (mask[0] & done) | (mask[1] & (timeout | err));
            bus.readdata <= readdata_n;
        end
    end
endmodule

// File: tb/tb_soc_system_pio_controle_start.sv
// tb_soc_system_pio_controle_start: directed bench with a read scoreboard for the launch controller.
module tb_soc_system_pio_controle_start;
    logic clk = 1'b0;
    logic reset_n;
    logic in_finish;
    logic out_port;
    logic irq;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    string tag_q[$];

    soc_system_pio_controle_start_if bus ();

    soc_system_pio_controle_start #(.PULSE_LEN(4), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave),
        .in_finish(in_finish), .out_port(out_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read value is queued when the read is issued and popped when readdata is valid.
    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string t);
        bus.address = a;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
        tick();
        bus.chipselect = 1'b0;
        chk(tag_q.pop_front(), bus.readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address = a;
        bus.writedata = d;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int hi;
        reset_n = 1'b0;
        in_finish = 1'b0;
        bus.address = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.writedata = 32'd0;
        repeat (2) tick();
        reset_n = 1'b1;
        rd(2'd0, 32'd0, "rst_ctrl");
        rd(2'd1, 32'd0, "rst_status");
        rd(2'd2, 32'd0, "rst_mask");
        rd(2'd3, 32'd0, "rst_cycles");
        chk("rst_out_port", {31'b0, out_port}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);

        // Normal run: finish rises 10 cycles after out_port rises.
        wr(2'd0, 32'd1);
        hi = 0;
        while (out_port === 1'b1 && hi < 20) begin
            hi++;
            tick();
        end
        chk("pulse_len", hi, 32'd4);
        rd(2'd0, 32'd1, "busy_in_run");
        repeat (5) tick();
        in_finish = 1'b1;
        tick();
        rd(2'd1, 32'd1, "status_done");
        rd(2'd3, 32'd11, "cycles_run");
        rd(2'd0, 32'd0, "busy_cleared");
        in_finish = 1'b0;

        // Early finish during PULSE with irq on done.
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd1);
        in_finish = 1'b1;
        tick();
        chk("early_out_port", {31'b0, out_port}, 32'd0);
        chk("irq_lag", {31'b0, irq}, 32'd0);
        tick();
        chk("irq_done", {31'b0, irq}, 32'd1);
        rd(2'd3, 32'd1, "cycles_early");
        in_finish = 1'b0;
        wr(2'd1, 32'd1);
        chk("irq_hold", {31'b0, irq}, 32'd1);
        tick();
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        rd(2'd1, 32'd0, "status_w1c");

        // Timeout after exactly 20 RUN cycles.
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd1);
        repeat (23) tick();
        rd(2'd0, 32'd1, "busy_run20");
        rd(2'd1, 32'd2, "status_timeout");
        chk("irq_timeout", {31'b0, irq}, 32'd1);
        chk("timeout_out_port", {31'b0, out_port}, 32'd0);
        rd(2'd0, 32'd0, "idle_after_timeout");
        rd(2'd3, 32'd24, "cycles_timeout");
        wr(2'd1, 32'd2);
        wr(2'd2, 32'd0);

        // Second start while busy: ignored, sets err.
        wr(2'd0, 32'd1);
        chk("start_out_port", {31'b0, out_port}, 32'd1);
        tick();
        wr(2'd0, 32'd1);
        hi = 2;
        while (out_port === 1'b1 && hi < 20) begin
            hi++;
            tick();
        end
        chk("single_pulse", hi, 32'd4);
        repeat (3) tick();
        chk("no_second_pulse", {31'b0, out_port}, 32'd0);
        rd(2'd1, 32'd4, "err_set");
        in_finish = 1'b1;
        tick();
        in_finish = 1'b0;
        rd(2'd1, 32'd5, "done_err");
        wr(2'd1, 32'd4);
        rd(2'd1, 32'd1, "err_cleared");
        wr(2'd1, 32'd1);

        // Reset in the middle of PULSE.
        wr(2'd2, 32'd3);
        wr(2'd0, 32'd1);
        tick();
        reset_n = 1'b0;
        tick();
        chk("reset_out_port", {31'b0, out_port}, 32'd0);
        chk("reset_irq", {31'b0, irq}, 32'd0);
        reset_n = 1'b1;
        rd(2'd0, 32'd0, "mid_rst_ctrl");
        rd(2'd2, 32'd0, "mid_rst_mask");
        rd(2'd3, 32'd0, "mid_rst_cycles");
        in_finish = 1'b1;
        tick();
        in_finish = 1'b0;
        rd(2'd1, 32'd0, "idle_fe_ignored");
        chk("idle_fe_out_port", {31'b0, out_port}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
